// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the registered N-to-1 stream multiplexer.
// Mode encodings and a clog2 that never returns zero.
package stream_mux_pkg;

    localparam logic MUX_MODE_SELECT = 1'b0;
    localparam logic MUX_MODE_RR     = 1'b1;

    // Width of an index able to address n entries; at least one bit.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr wins,
// searching upwards and wrapping. Double-width rotate, then priority encode.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = clog2_safe(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    logic [SEL_W:0]            start;
    logic [SEL_W:0]            off;
    logic [SEL_W:0]            sum;
    logic [2*CHANNELS-1:0]     rot_full;
    logic [CHANNELS-1:0]       req_rot;
    logic                      found;

    always_comb begin
        start = '0;
        if (ptr < SEL_W'(CHANNELS - 1)) begin
            start = {1'b0, ptr} + (SEL_W + 1)'(1);
        end
        rot_full = {req, req} >> start;
        req_rot  = rot_full[CHANNELS-1:0];

        found = 1'b0;
        off   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = (SEL_W + 1)'(i);
            end
        end

        // Undo the rotation: offset from start, folded back into range.
        sum = start + off;
        if (sum >= (SEL_W + 1)'(CHANNELS)) begin
            sum = sum - (SEL_W + 1)'(CHANNELS);
        end

        gnt_valid = |req;
        gnt_idx   = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 registered stream mux with explicit-select or round-robin arbitration.
// One output register: 1-cycle latency, full throughput under continuous ready.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = clog2_safe(CHANNELS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            select,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SEL_W-1:0]            out_channel
);

    logic [WIDTH-1:0] ch_data [CHANNELS];

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_channel_q, out_channel_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               rr_valid;
    logic [SEL_W-1:0]   rr_idx;
    logic               sel_valid;
    logic               gnt_valid;
    logic [SEL_W-1:0]   gnt_idx;
    logic               load_en;
    logic               xfer;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = xfer && (gnt_idx == SEL_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        load_en   = !out_valid_q || out_ready;
        sel_valid = 1'b0;
        if (select <= SEL_W'(CHANNELS - 1)) begin
            sel_valid = in_valid[select];
        end

        if (mode == MUX_MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = sel_valid;
            gnt_idx   = select;
        end

        // Reset gating keeps producers from seeing an accept that the flops ignore.
        xfer = load_en && gnt_valid && !reset;

        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        rr_ptr_d      = rr_ptr_q;

        if (xfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = ch_data[gnt_idx];
            out_channel_d = gnt_idx;
            if (mode == MUX_MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            rr_ptr_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed vector table, async reset check, then
// randomized traffic compared against a queue-free behavioural model.
module tb_stream_mux_rr;

    localparam int W  = 32;
    localparam int CH = 8;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic [SW-1:0]     select;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_channel;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        mode;
        logic [2:0]  sel;
        logic [7:0]  valid;
        logic        rdy;
        logic [7:0]  exp_rdy;
        logic        exp_ov;
        logic [2:0]  exp_ch;
    } vec_t;

    vec_t vecs[24];

    // Model state: the held beat and the last round-robin winner.
    logic        m_valid;
    logic [W-1:0] m_data;
    int          m_chan;
    int          m_ptr;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .select      (select),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_channel (out_channel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Grant from the arbitration rules: fixed select, or first valid after ptr.
    function automatic int ref_grant(input logic m, input int sel, input logic [7:0] v, input int ptr);
        if (m == 1'b0) begin
            if (sel < CH && v[sel]) return sel;
            return -1;
        end
        for (int i = 1; i <= CH; i++) begin
            int k;
            k = (ptr + i) % CH;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input logic m, input logic [2:0] s, input logic [7:0] v,
                                input logic r, input logic [7:0] er, input logic eo,
                                input logic [2:0] ec);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.rdy = r;
        t.exp_rdy = er; t.exp_ov = eo; t.exp_ch = ec;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        logic load;
        logic [7:0] exp_rdy;

        // Directed table: explicit select, RR sweep, backpressure, sparse wrap, mode switch.
        vecs[0] = mk(1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5);
        for (int k = 0; k < 10; k++) begin
            vecs[1 + k] = mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1, 3'(k % 8));
        end
        vecs[11] = mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd1);
        vecs[12] = mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd1);
        vecs[13] = mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd1);
        vecs[14] = mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2);
        vecs[15] = mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7);
        vecs[16] = mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0);
        vecs[17] = mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7);
        vecs[18] = mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0);
        vecs[19] = mk(1'b0, 3'd3, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0);
        vecs[20] = mk(1'b0, 3'd3, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
        vecs[21] = mk(1'b0, 3'd0, 8'h81, 1'b0, 8'h01, 1'b1, 3'd0);
        vecs[22] = mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd0);
        vecs[23] = mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1);

        reset     = 1'b1;
        mode      = 1'b1;
        select    = '0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < CH; k++) in_data[k*W +: W] = 32'hA5A5_0000 | 32'(k);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_channel", 32'(out_channel), 32'h0);
        reset = 1'b0;
        #1;
        check("rst_first_rr_grant", 32'(in_ready), 32'h01);

        for (int i = 0; i < 24; i++) begin
            mode      = vecs[i].mode;
            select    = vecs[i].sel;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_channel", i), 32'(out_channel), 32'(vecs[i].exp_ch));
            check($sformatf("vec%0d_out_data", i), out_data, 32'hA5A5_0000 | 32'(vecs[i].exp_ch));
            $display("vec %0d: mode=%0d sel=%0d valid=%h rdy=%0d -> out_valid=%0d ch=%0d data=%h",
                     i, mode, select, in_valid, out_ready, out_valid, out_channel, out_data);
        end

        // Asynchronous reset in mid-cycle while a beat is held.
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_in_ready", 32'(in_ready), 32'h0);
        check("async_rst_out_data", out_data, 32'h0);
        $display("async reset mid-cycle: out_valid=%0d in_ready=%h", out_valid, in_ready);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = CH - 1;

        // Randomized traffic against the behavioural model.
        for (int c = 0; c < 600; c++) begin
            mode      = 1'($urandom_range(0, 1));
            select    = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < CH; k++) in_data[k*W +: W] = $urandom;
            #1;
            g       = ref_grant(mode, int'(select), in_valid, m_ptr);
            load    = !m_valid || out_ready;
            exp_rdy = (load && g >= 0) ? 8'(1 << g) : 8'h00;
            check($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy));
            @(posedge clk);
            #1;
            if (load && g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_chan  = g;
                if (mode) m_ptr = g;
            end else if (load) begin
                m_valid = 1'b0;
            end
            check($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(m_valid));
            check($sformatf("rnd%0d_out_channel", c), 32'(out_channel), 32'(m_chan));
            check($sformatf("rnd%0d_out_data", c), out_data, m_data);
            if (load && g >= 0) begin
                $display("rnd %0d: mode=%0d accepted ch=%0d data=%h", c, mode, g, in_data[g*W +: W]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
